csr_file: RTL
=============

Name: csr_file

Overview:
- Machine-mode CSR register file.
- Responder end of the writeback trap/CSR interface:
  - Accepts generic CSR writes and trap-side writes (mcause/mtval/mepc, mstatus MIE/MPIE updates) from the writeback stage.
  - Returns CSR read data to the execute stage.
  - Supplies interrupt-enable/pending and mtvec/mepc values back to writeback.
- Owns the mcycle/minstret counters and a cycle-compare timer that drives MTIP.

Parameters:
XLEN, 64, register width
MTIMECMP_IDX, 12'h7C1, CSR index of the custom timer-compare register
MISA_VAL, 64'h8000_0000_0000_0100, read-only misa value (RV64I)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
csr_ridx_i  in  12  read index (execute stage)
csr_rdata_o  out  XLEN  combinational read data
csr_ridx_illegal_o  out  1  read index unimplemented
csr_wen_i  in  1  software CSR write enable (writeback)
csr_widx_i  in  12  software CSR write index
csr_wdata_i  in  XLEN  software CSR write data
mcause_wen_i  in  1  trap write of mcause
mcause_wdata_i  in  XLEN  mcause value
mtval_wen_i  in  1  trap write of mtval
mtval_wdata_i  in  XLEN  mtval value
mepc_wen_i  in  1  trap write of mepc
mepc_wdata_i  in  XLEN  mepc value
mstatus_mie_set_i  in  1  trap entry: MPIE<=MIE, MIE<=0
mstatus_mie_clear_i  in  1  mret: MIE<=MPIE, MPIE<=1
instr_retire_i  in  1  one instruction retired this cycle
ext_irq_i  in  1  external interrupt level (MEIP)
mstatus_mie_rdata_o  out  1  mstatus.MIE
mie_meie_rdata_o / mie_mtie_rdata_o / mie_msie_rdata_o  out  1 each  mie bits 11/7/3
mip_meip_rdata_o / mip_mtip_rdata_o / mip_msip_rdata_o  out  1 each  mip bits 11/7/3
mtvec_rdata_o  out  XLEN  mtvec
mepc_rdata_o  out  XLEN  mepc

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: MIE bit 3, MPIE bit 7, MPP[12:11] hardwired 2'b11, all other bits read 0.
  - misa 0x301: read-only MISA_VAL; writes ignored.
  - mie 0x304: bits 11/7/3 writable, others 0.
  - mtvec 0x305: bits[1:0] forced 0 (direct mode).
  - mscratch 0x340: full width.
  - mepc 0x341: bits[1:0] forced 0 on every write path.
  - mcause 0x342 and mtval 0x343: full width.
  - mip 0x344: only MSIP bit 3 writable; MEIP = ext_irq_i registered one cycle; MTIP = (mcycle >= mtimecmp), combinational, unsigned compare.
  - mcycle 0xB00, minstret 0xB02, mtimecmp at MTIMECMP_IDX.
- Any other read index: rdata = 0, csr_ridx_illegal_o = 1.
- Reads are combinational from current register state. A write in cycle N is visible on reads in cycle N+1. A same-cycle read returns the old value.
- All writes take effect at the clk_i edge.
- Priority per register:
  - mepc/mcause/mtval: trap write > software write.
  - mstatus: mstatus_mie_set_i > mstatus_mie_clear_i > software write. If set and clear are asserted together, set wins (trap entry).
- mcycle: increments by 1 every cycle after reset; a software write in a cycle replaces that cycle's increment. Wraps 2^64-1 -> 0.
- minstret: increments when instr_retire_i=1; a software write wins over a simultaneous retire. Wraps the same way.
- Reset values (rst_i sampled high at the edge):
  - mstatus MIE=0, MPIE=0.
  - mie=0, mip MSIP=0, MEIP register=0.
  - mtvec=0, mepc=0, mcause=0, mtval=0, mscratch=0.
  - mcycle=0, minstret=0.
  - mtimecmp = all ones, so MTIP=0 after reset.
- Reset asserted mid-operation overrides every pending write in that cycle.
- Dedicated *_rdata_o outputs reflect the registers directly, zero latency.

Test Plan:
- Reset, then idle 3 cycles -> mcycle reads 3, minstret 0, mtvec_rdata_o 0, mip_mtip 0, all interrupt outputs 0.
- Software write mtvec=0x8000_0003 -> next-cycle read 0x8000_0000; same-cycle read returns old value 0.
- Write MIE=1 via mstatus 0x8, then pulse mstatus_mie_set_i -> MIE=0, MPIE=1; then pulse mstatus_mie_clear_i -> MIE=1, MPIE=1. Mstatus read returns 0x1888.
- Same cycle: mepc_wen_i with 0x1000 and csr_wen_i to 0x341 with 0x2000 -> mepc=0x1000. Software write of 0x2002 alone -> mepc=0x2000.
- Write mtimecmp = current mcycle+5 -> mip_mtip_rdata_o rises exactly when mcycle equals that value. Rewriting mtimecmp to all ones drops it the next cycle.
- Write mcycle=0xFFFF_FFFF_FFFF_FFFF -> reads 0 one cycle later. Assert instr_retire_i and a minstret write of 7 in the same cycle -> reads 7. Read index 0x7FF -> rdata 0, illegal=1.

Source files
------------

// File: rtl/csr_file_if.sv
`default_nettype none
// ============================================================================
// Module   : csr_file_if
// Purpose  : Writeback/execute <-> CSR file bundle. Carries the read port,
//            the software and trap write ports, counter/interrupt inputs and
//            the dedicated register taps returned to writeback.
// Revision : 1.0 - initial release
// ============================================================================
interface csr_file_if #(
  parameter int XLEN = 64
);
  // Read port (execute stage)
  logic [11:0]     csr_ridx_i;
  logic [XLEN-1:0] csr_rdata_o;
  logic            csr_ridx_illegal_o;

  // Software write port (writeback stage)
  logic            csr_wen_i;
  logic [11:0]     csr_widx_i;
  logic [XLEN-1:0] csr_wdata_i;

  // Trap-side writes
  logic            mcause_wen_i;
  logic [XLEN-1:0] mcause_wdata_i;
  logic            mtval_wen_i;
  logic [XLEN-1:0] mtval_wdata_i;
  logic            mepc_wen_i;
  logic [XLEN-1:0] mepc_wdata_i;
  logic            mstatus_mie_set_i;
  logic            mstatus_mie_clear_i;

  // Event / interrupt inputs
  logic            instr_retire_i;
  logic            ext_irq_i;

  // Dedicated register taps
  logic            mstatus_mie_rdata_o;
  logic            mie_meie_rdata_o;
  logic            mie_mtie_rdata_o;
  logic            mie_msie_rdata_o;
  logic            mip_meip_rdata_o;
  logic            mip_mtip_rdata_o;
  logic            mip_msip_rdata_o;
  logic [XLEN-1:0] mtvec_rdata_o;
  logic [XLEN-1:0] mepc_rdata_o;

  // Pipeline side: drives indices, writes and events
  modport master (
    output csr_ridx_i,
    input  csr_rdata_o, csr_ridx_illegal_o,
    output csr_wen_i, csr_widx_i, csr_wdata_i,
    output mcause_wen_i, mcause_wdata_i, mtval_wen_i, mtval_wdata_i,
    output mepc_wen_i, mepc_wdata_i, mstatus_mie_set_i, mstatus_mie_clear_i,
    output instr_retire_i, ext_irq_i,
    input  mstatus_mie_rdata_o, mie_meie_rdata_o, mie_mtie_rdata_o, mie_msie_rdata_o,
    input  mip_meip_rdata_o, mip_mtip_rdata_o, mip_msip_rdata_o,
    input  mtvec_rdata_o, mepc_rdata_o
  );

  // CSR file side
  modport slave (
    input  csr_ridx_i,
    output csr_rdata_o, csr_ridx_illegal_o,
    input  csr_wen_i, csr_widx_i, csr_wdata_i,
    input  mcause_wen_i, mcause_wdata_i, mtval_wen_i, mtval_wdata_i,
    input  mepc_wen_i, mepc_wdata_i, mstatus_mie_set_i, mstatus_mie_clear_i,
    input  instr_retire_i, ext_irq_i,
    output mstatus_mie_rdata_o, mie_meie_rdata_o, mie_mtie_rdata_o, mie_msie_rdata_o,
    output mip_meip_rdata_o, mip_mtip_rdata_o, mip_msip_rdata_o,
    output mtvec_rdata_o, mepc_rdata_o
  );
endinterface
`default_nettype wire

// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module   : csr_file
// Purpose  : Machine-mode CSR register file. Software and trap write ports,
//            combinational read port, mcycle/minstret counters and a
//            cycle-compare timer that raises MTIP.
// Revision : 1.0 - initial release
// ============================================================================
module csr_file #(
  parameter int              XLEN         = 64,
  parameter logic [11:0]     MTIMECMP_IDX = 12'h7C1,
  parameter logic [XLEN-1:0] MISA_VAL     = 64'h8000_0000_0000_0100
) (
  input  wire logic   clk_i,
  input  wire logic   rst_i,
  csr_file_if.slave   bus
);

  localparam logic [11:0] c_IDX_MSTATUS  = 12'h300;
  localparam logic [11:0] c_IDX_MISA     = 12'h301;
  localparam logic [11:0] c_IDX_MIE      = 12'h304;
  localparam logic [11:0] c_IDX_MTVEC    = 12'h305;
  localparam logic [11:0] c_IDX_MSCRATCH = 12'h340;
  localparam logic [11:0] c_IDX_MEPC     = 12'h341;
  localparam logic [11:0] c_IDX_MCAUSE   = 12'h342;
  localparam logic [11:0] c_IDX_MTVAL    = 12'h343;
  localparam logic [11:0] c_IDX_MIP      = 12'h344;
  localparam logic [11:0] c_IDX_MCYCLE   = 12'hB00;
  localparam logic [11:0] c_IDX_MINSTRET = 12'hB02;

  // --------------------------------------------------------------------------
  // Architectural state
  // --------------------------------------------------------------------------
  logic            r_mstatus_mie;
  logic            r_mstatus_mpie;
  logic            r_mie_meie;
  logic            r_mie_mtie;
  logic            r_mie_msie;
  logic            r_mip_msip;
  logic            r_mip_meip;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;
  logic [XLEN-1:0] r_mcycle;
  logic [XLEN-1:0] r_minstret;
  logic [XLEN-1:0] r_mtimecmp;

  // --------------------------------------------------------------------------
  // Software write decode
  // --------------------------------------------------------------------------
  logic w_wr_mstatus;
  logic w_wr_mie;
  logic w_wr_mtvec;
  logic w_wr_mscratch;
  logic w_wr_mepc;
  logic w_wr_mcause;
  logic w_wr_mtval;
  logic w_wr_mip;
  logic w_wr_mcycle;
  logic w_wr_minstret;
  logic w_wr_mtimecmp;

  assign w_wr_mstatus  = bus.csr_wen_i && (bus.csr_widx_i == c_IDX_MSTATUS);
  assign w_wr_mie      = bus.csr_wen_i && (bus.csr_widx_i == c_IDX_MIE);
  assign w_wr_mtvec    = bus.csr_wen_i && (bus.csr_widx_i == c_IDX_MTVEC);
  assign w_wr_mscratch = bus.csr_wen_i && (bus.csr_widx_i == c_IDX_MSCRATCH);
  assign w_wr_mepc     = bus.csr_wen_i && (bus.csr_widx_i == c_IDX_MEPC);
  assign w_wr_mcause   = bus.csr_wen_i && (bus.csr_widx_i == c_IDX_MCAUSE);
  assign w_wr_mtval    = bus.csr_wen_i && (bus.csr_widx_i == c_IDX_MTVAL);
  assign w_wr_mip      = bus.csr_wen_i && (bus.csr_widx_i == c_IDX_MIP);
  assign w_wr_mcycle   = bus.csr_wen_i && (bus.csr_widx_i == c_IDX_MCYCLE);
  assign w_wr_minstret = bus.csr_wen_i && (bus.csr_widx_i == c_IDX_MINSTRET);
  assign w_wr_mtimecmp = bus.csr_wen_i && (bus.csr_widx_i == MTIMECMP_IDX);

  // Timer interrupt: unsigned compare of the free-running cycle counter
  logic w_mtip;
  assign w_mtip = (r_mcycle >= r_mtimecmp);

  // mstatus: trap entry beats mret, which beats a software write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
    end else if (bus.mstatus_mie_set_i) begin
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
    end else if (bus.mstatus_mie_clear_i) begin
      r_mstatus_mie  <= r_mstatus_mpie;
      r_mstatus_mpie <= 1'b1;
    end else if (w_wr_mstatus) begin
      r_mstatus_mie  <= bus.csr_wdata_i[3];
      r_mstatus_mpie <= bus.csr_wdata_i[7];
    end
  end

  // mie enables and software-writable MSIP; MEIP samples the external line
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mie_meie <= 1'b0;
      r_mie_mtie <= 1'b0;
      r_mie_msie <= 1'b0;
      r_mip_msip <= 1'b0;
      r_mip_meip <= 1'b0;
    end else begin
      r_mip_meip <= bus.ext_irq_i;
      if (w_wr_mie) begin
        r_mie_meie <= bus.csr_wdata_i[11];
        r_mie_mtie <= bus.csr_wdata_i[7];
        r_mie_msie <= bus.csr_wdata_i[3];
      end
      if (w_wr_mip) begin
        r_mip_msip <= bus.csr_wdata_i[3];
      end
    end
  end

  // mtvec (direct mode only) and mscratch: software-written only
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mtvec    <= '0;
      r_mscratch <= '0;
    end else begin
      if (w_wr_mtvec) begin
        r_mtvec <= {bus.csr_wdata_i[XLEN-1:2], 2'b00};
      end
      if (w_wr_mscratch) begin
        r_mscratch <= bus.csr_wdata_i;
      end
    end
  end

  // Trap registers: the trap write port wins over a software write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mepc   <= '0;
      r_mcause <= '0;
      r_mtval  <= '0;
    end else begin
      if (bus.mepc_wen_i) begin
        r_mepc <= {bus.mepc_wdata_i[XLEN-1:2], 2'b00};
      end else if (w_wr_mepc) begin
        r_mepc <= {bus.csr_wdata_i[XLEN-1:2], 2'b00};
      end
      if (bus.mcause_wen_i) begin
        r_mcause <= bus.mcause_wdata_i;
      end else if (w_wr_mcause) begin
        r_mcause <= bus.csr_wdata_i;
      end
      if (bus.mtval_wen_i) begin
        r_mtval <= bus.mtval_wdata_i;
      end else if (w_wr_mtval) begin
        r_mtval <= bus.csr_wdata_i;
      end
    end
  end

  // Counters: a software write replaces the cycle's increment; both wrap
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_wr_mcycle) begin
        r_mcycle <= bus.csr_wdata_i;
      end else begin
        r_mcycle <= r_mcycle + XLEN'(1);
      end
      if (w_wr_minstret) begin
        r_minstret <= bus.csr_wdata_i;
      end else if (bus.instr_retire_i) begin
        r_minstret <= r_minstret + XLEN'(1);
      end
    end
  end

  // Timer compare resets to all ones so MTIP stays low out of reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mtimecmp <= '1;
    end else if (w_wr_mtimecmp) begin
      r_mtimecmp <= bus.csr_wdata_i;
    end
  end

  // --------------------------------------------------------------------------
  // Architectural views of the packed registers
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] w_mstatus;
  logic [XLEN-1:0] w_mie;
  logic [XLEN-1:0] w_mip;

  // Assemble mstatus/mie/mip with unimplemented bits reading zero
  always_comb begin
    w_mstatus        = '0;
    w_mstatus[12:11] = 2'b11;
    w_mstatus[7]     = r_mstatus_mpie;
    w_mstatus[3]     = r_mstatus_mie;
    w_mie            = '0;
    w_mie[11]        = r_mie_meie;
    w_mie[7]         = r_mie_mtie;
    w_mie[3]         = r_mie_msie;
    w_mip            = '0;
    w_mip[11]        = r_mip_meip;
    w_mip[7]         = w_mtip;
    w_mip[3]         = r_mip_msip;
  end

  logic [XLEN-1:0] w_rdata;
  logic            w_ridx_illegal;

  // Combinational read mux; unknown indices return zero and flag illegal
  always_comb begin
    w_rdata        = '0;
    w_ridx_illegal = 1'b0;
    case (bus.csr_ridx_i)
      c_IDX_MSTATUS:  w_rdata = w_mstatus;
      c_IDX_MISA:     w_rdata = MISA_VAL;
      c_IDX_MIE:      w_rdata = w_mie;
      c_IDX_MTVEC:    w_rdata = r_mtvec;
      c_IDX_MSCRATCH: w_rdata = r_mscratch;
      c_IDX_MEPC:     w_rdata = r_mepc;
      c_IDX_MCAUSE:   w_rdata = r_mcause;
      c_IDX_MTVAL:    w_rdata = r_mtval;
      c_IDX_MIP:      w_rdata = w_mip;
      c_IDX_MCYCLE:   w_rdata = r_mcycle;
      c_IDX_MINSTRET: w_rdata = r_minstret;
      MTIMECMP_IDX:   w_rdata = r_mtimecmp;
      default:        w_ridx_illegal = 1'b1;
    endcase
  end

  assign bus.csr_rdata_o         = w_rdata;
  assign bus.csr_ridx_illegal_o  = w_ridx_illegal;
  assign bus.mstatus_mie_rdata_o = r_mstatus_mie;
  assign bus.mie_meie_rdata_o    = r_mie_meie;
  assign bus.mie_mtie_rdata_o    = r_mie_mtie;
  assign bus.mie_msie_rdata_o    = r_mie_msie;
  assign bus.mip_meip_rdata_o    = r_mip_meip;
  assign bus.mip_mtip_rdata_o    = w_mtip;
  assign bus.mip_msip_rdata_o    = r_mip_msip;
  assign bus.mtvec_rdata_o       = r_mtvec;
  assign bus.mepc_rdata_o        = r_mepc;

endmodule
`default_nettype wire
